// File: rtl/mii_pkg.sv
// Shared constants, FSM encoding and helpers for the MII byte-level receive path.
// No logic of its own; imported by the framer and its CRC step.
package mii_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    // End-of-frame status bundle, registered together on the eof strobe.
    typedef struct packed {
        logic [10:0] len;
        logic        crc_ok;
        logic        bad;
    } eof_stat_t;

    function automatic logic [3:0] rev4(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte parallel step of the reflected CRC-32 (LSB-first byte update).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register crc_out.
module crc32_d8
    import mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc_out
);

    logic [31:0] acc;

    always_comb begin
        acc = crc_in ^ {24'h0, data_byte};
        for (int i = 0; i < 8; i++) begin
            acc = acc[0] ? ((acc >> 1) ^ CRC32_POLY) : (acc >> 1);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/mii_frame_rx.sv
// Ethernet receive framer: strips preamble/SFD, forwards frame bytes, reports length/CRC/errors.
// Latency: data one cycle after the byte strobe; eof status one cycle after the frame-end cycle.
// Backpressure: none; the MII stream cannot be stalled, every strobe is consumed.
module mii_frame_rx
    import mii_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_rdy,
    input  logic [7:0]  in_d,
    input  logic        in_en,
    input  logic        in_err,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic [10:0] out_len,
    output logic        out_crc_ok,
    output logic        out_bad,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;
    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    rx_state_e   state;
    rx_state_e   state_nxt;

    logic [7:0]  wire_byte;
    logic        frame_end;
    logic        armed;

    logic [31:0] crc_q;
    logic [31:0] crc_step;
    logic [10:0] len_q;
    logic        err_q;
    logic        first_q;

    logic        sfd_hit;
    logic        fwd;
    logic        eof_set;
    logic        err_cyc;

    eof_stat_t   stat_nxt;

    assign wire_byte = {rev4(in_d[7:4]), rev4(in_d[3:0])};

    // The byte strobe lags RX_DV by a cycle, so a frame only ends once both are low.
    assign frame_end = !in_en && !in_rdy;

    crc32_d8 u_crc (
        .crc_in    (crc_q),
        .data_byte (wire_byte),
        .crc_out   (crc_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (in_en && armed) begin
                    state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (!in_en) begin
                    state_nxt = ST_IDLE;
                end else if (in_rdy) begin
                    if (wire_byte == SFD_BYTE) begin
                        state_nxt = ST_DATA;
                    end else if (wire_byte != PREAMBLE_BYTE) begin
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_DATA, ST_DROP: begin
                if (frame_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sfd_hit = (state == ST_PREAMBLE) && in_en && in_rdy && (wire_byte == SFD_BYTE);
        fwd     = (state == ST_DATA) && in_rdy;
        eof_set = (state == ST_DATA) && frame_end;
        err_cyc = (state == ST_DATA) && in_err;
    end

    always_comb begin
        stat_nxt        = '0;
        stat_nxt.len    = len_q;
        stat_nxt.crc_ok = (crc_q == CRC32_RESIDUE);
        stat_nxt.bad    = err_q || err_cyc || (len_q < LEN_MIN) || (len_q > LEN_MAX) ||
                          (crc_q != CRC32_RESIDUE);
    end

    // After reset the block waits for an inter-frame gap so it never locks on mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (!in_en) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q   <= CRC32_INIT;
            len_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else if (sfd_hit) begin
            crc_q   <= CRC32_INIT;
            len_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            if (fwd) begin
                crc_q   <= crc_step;
                first_q <= 1'b0;
                if (len_q != LEN_SAT) begin
                    len_q <= len_q + 11'd1;
                end
            end
            if (err_cyc) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
        end else begin
            out_valid <= fwd;
            out_sof   <= fwd && first_q;
            if (fwd) begin
                out_data <= wire_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_eof    <= 1'b0;
            out_len    <= '0;
            out_crc_ok <= 1'b0;
            out_bad    <= 1'b0;
        end else begin
            out_eof <= eof_set;
            if (eof_set) begin
                out_len    <= stat_nxt.len;
                out_crc_ok <= stat_nxt.crc_ok;
                out_bad    <= stat_nxt.bad;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frames_ok  <= '0;
            frames_bad <= '0;
        end else if (out_eof) begin
            if (out_bad) begin
                if (frames_bad != CNT_SAT) begin
                    frames_bad <= frames_bad + 16'd1;
                end
            end else if (frames_ok != CNT_SAT) begin
                frames_ok <= frames_ok + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mii_frame_rx.sv
// Directed bench for mii_frame_rx: builds frames with their own FCS, drives MII-style
// byte strobes every other cycle, and checks forwarding, eof status and counters.
module tb_mii_frame_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_rdy;
    logic [7:0]  in_d;
    logic        in_en;
    logic        in_err;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic [10:0] out_len;
    logic        out_crc_ok;
    logic        out_bad;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;

    always #5 clk = ~clk;

    mii_frame_rx #(
        .MIN_LEN (64),
        .MAX_LEN (1518)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_rdy     (in_rdy),
        .in_d       (in_d),
        .in_en      (in_en),
        .in_err     (in_err),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_len    (out_len),
        .out_crc_ok (out_crc_ok),
        .out_bad    (out_bad),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] frm[$];

    // Output monitor: cumulative totals, read as deltas by the stimulus.
    int m_valid = 0;
    int m_sof   = 0;
    int m_eof   = 0;
    int m_dmis  = 0;
    int m_idx   = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            if (out_sof) begin
                m_sof = m_sof + 1;
                m_idx = 0;
            end
            if (m_idx >= frm.size()) begin
                m_dmis = m_dmis + 1;
            end else if (out_data !== frm[m_idx]) begin
                m_dmis = m_dmis + 1;
            end
            m_idx   = m_idx + 1;
            m_valid = m_valid + 1;
        end
        if (out_eof) begin
            m_eof = m_eof + 1;
        end
    end

    int s_valid, s_sof, s_eof, s_dmis;
    int exp_ok  = 0;
    int exp_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_mii(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[3-i] = b[i];
            r[7-i] = b[4+i];
        end
        return r;
    endfunction

    // Bit-serial reference CRC over the frame body, FCS appended complemented LSB byte first.
    task automatic build(input int n, input int seed);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        frm.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = 8'((i * 13 + seed * 29 + 7) & 255);
            frm.push_back(b);
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic cyc(input logic en, input logic rdy, input logic [7:0] b, input logic er);
        in_en  = en;
        in_rdy = rdy;
        in_d   = to_mii(b);
        in_err = er;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic snap();
        s_valid = m_valid;
        s_sof   = m_sof;
        s_eof   = m_eof;
        s_dmis  = m_dmis;
    endtask

    // Last byte is strobed after RX_DV has already dropped, as the assembler does.
    task automatic tx(input int npre, input int bad_pre_idx, input int err_idx,
                      input int rst_idx, input logic exp_eof);
        logic er;
        for (int p = 0; p < npre; p++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            cyc(1'b1, 1'b1, (p == bad_pre_idx) ? 8'h57 : 8'h55, 1'b0);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == rst_idx) begin
                cyc(1'b1, 1'b0, 8'h00, 1'b0);
                reset_n = 1'b0;
                #1;
                chk("rst_out_len", 32'(out_len), 32'd0);
                chk("rst_frames_ok", 32'(frames_ok), 32'd0);
                chk("rst_frames_bad", 32'(frames_bad), 32'd0);
                chk("rst_flags", 32'({out_valid, out_sof, out_eof, out_crc_ok, out_bad}), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
            end
            er = (i == err_idx);
            cyc(1'b1, 1'b0, 8'h00, er);
            if (i == frm.size() - 1) cyc(1'b0, 1'b1, frm[i], er);
            else                     cyc(1'b1, 1'b1, frm[i], er);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("eof_strobe", 32'(out_eof), 32'(exp_eof));
    endtask

    task automatic post(input string nm, input int e_valid, input int e_sof, input int e_eof,
                        input int e_len, input logic e_crc, input logic e_bad);
        chk({nm, "_valid_cnt"}, 32'(m_valid - s_valid), 32'(e_valid));
        chk({nm, "_sof_cnt"}, 32'(m_sof - s_sof), 32'(e_sof));
        chk({nm, "_data_mis"}, 32'(m_dmis - s_dmis), 32'd0);
        chk({nm, "_eof_cnt"}, 32'(m_eof - s_eof), 32'(e_eof));
        chk({nm, "_len"}, 32'(out_len), 32'(e_len));
        chk({nm, "_crc_ok"}, 32'(out_crc_ok), 32'(e_crc));
        chk({nm, "_bad"}, 32'(out_bad), 32'(e_bad));
        chk({nm, "_frames_ok"}, 32'(frames_ok), 32'(exp_ok));
        chk({nm, "_frames_bad"}, 32'(frames_bad), 32'(exp_bad));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        in_en   = 1'b0;
        in_rdy  = 1'b0;
        in_d    = 8'h00;
        in_err  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({out_valid, out_sof, out_eof, out_crc_ok, out_bad}), 32'd0);
        chk("reset_data_len", 32'({out_data, out_len}), 32'd0);
        chk("reset_counters", {frames_ok, frames_bad}, 32'd0);
        reset_n = 1'b1;
        idle(3);

        // Minimum-length good frame.
        build(64, 1); snap();
        tx(7, -1, -1, -1, 1'b1); idle(3);
        exp_ok = 1;
        post("good64", 64, 1, 1, 64, 1'b1, 1'b0);

        // Single payload bit flipped: FCS no longer matches, bytes still forwarded.
        build(64, 1); frm[10] = frm[10] ^ 8'h04; snap();
        tx(7, -1, -1, -1, 1'b1); idle(3);
        exp_bad = 1;
        post("crcerr", 64, 1, 1, 64, 1'b0, 1'b1);

        // Runt with valid FCS.
        build(40, 2); snap();
        tx(7, -1, -1, -1, 1'b1); idle(3);
        exp_bad = 2;
        post("runt", 40, 1, 1, 40, 1'b1, 1'b1);

        // Corrupt preamble: whole frame dropped, eof status of the runt still held.
        build(64, 3); snap();
        tx(7, 1, -1, -1, 1'b0); idle(3);
        post("drop", 0, 0, 0, 40, 1'b1, 1'b1);

        // RX_ER during byte 20 of an otherwise good frame.
        build(100, 4); snap();
        tx(7, -1, 20, -1, 1'b1); idle(3);
        exp_bad = 3;
        post("rxerr", 100, 1, 1, 100, 1'b1, 1'b1);

        // Reset at byte 30, released with RX_DV still high: remainder ignored.
        build(64, 5); snap();
        tx(7, -1, -1, 30, 1'b0); idle(3);
        exp_ok  = 0;
        exp_bad = 0;
        post("midrst", 30, 1, 0, 0, 1'b0, 1'b0);

        build(64, 6); snap();
        tx(7, -1, -1, -1, 1'b1); idle(3);
        exp_ok = 1;
        post("afterrst", 64, 1, 1, 64, 1'b1, 1'b0);

        // Back-to-back: next frame's RX_DV rises in the eof cycle, no preamble at all.
        build(64, 7); snap();
        tx(3, -1, -1, -1, 1'b1);
        tx(0, -1, -1, -1, 1'b1); idle(3);
        exp_ok = 3;
        post("b2b", 128, 2, 2, 64, 1'b1, 1'b0);

        // One byte over the maximum: flagged bad but fully forwarded.
        build(1519, 8); snap();
        tx(7, -1, -1, -1, 1'b1); idle(3);
        exp_bad = 1;
        post("oversize", 1519, 1, 1, 1519, 1'b1, 1'b1);

        // Exactly the maximum length is legal.
        build(1518, 9); snap();
        tx(7, -1, -1, -1, 1'b1); idle(3);
        exp_ok = 4;
        post("maxlen", 1518, 1, 1, 1518, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
